button_debounce: RTL and testbench

//   Input-side counterpart to the LED blink outputs: conditions one raw

---
 rtl/button_debounce_sync_2ff.sv | 27 ++
 rtl/button_debounce.sv | 119 +++++++++++
 tb/tb_button_debounce.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchroniser for one asynchronous pin into the clk_i domain.
// Latency 2 cycles; no backpressure. Synchronous reset loads RESET_VAL into both stages.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, then press/release/long-press strobes and press count.
// Latency 2 + DB_CNT cycles from a clean pin edge to `pressed`; no backpressure, strobes last one cycle.
module button_debounce #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int DEBOUNCE_MS   = 10,
   parameter int LONG_PRESS_MS = 1000,
   parameter int ACTIVE_LOW    = 1,
   parameter int COUNT_W       = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               BTN_IN,
   output logic               pressed,
   output logic               press_pulse,
   output logic               release_pulse,
   output logic               long_press,
   output logic [COUNT_W-1:0] press_count
);

   localparam logic [63:0] DB_CNT = 64'(CLK_FREQ) / 64'd1000 * 64'(DEBOUNCE_MS);
   localparam logic [63:0] LP_CNT = 64'(CLK_FREQ) / 64'd1000 * 64'(LONG_PRESS_MS);
   localparam int          DB_W   = $clog2(DB_CNT + 64'd1);
   localparam int          LP_W   = $clog2(LP_CNT + 64'd1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CNT - 64'd1);
   localparam logic [LP_W-1:0] LP_MAX = LP_W'(LP_CNT - 64'd1);
   localparam logic        POL      = (ACTIVE_LOW != 0);
   localparam logic        RELEASED = 1'b0;
   localparam logic        PRESSED  = 1'b1;

   logic               btn_norm;
   logic               synced;

   logic               state_q,         state_d;
   logic [DB_W-1:0]    db_cnt_q,        db_cnt_d;
   logic [LP_W-1:0]    lp_cnt_q,        lp_cnt_d;
   logic               press_pulse_q,   press_pulse_d;
   logic               release_pulse_q, release_pulse_d;
   logic               long_press_q,    long_press_d;
   logic [COUNT_W-1:0] press_cnt_q,     press_cnt_d;

   // Normalise polarity before the first flop so synced 1 always means pressed.
   assign btn_norm = BTN_IN ^ POL;

   sync_2ff #(
      .RESET_VAL (1'b0)
   ) u_sync (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (btn_norm),
      .q_o   (synced)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q         <= RELEASED;
         db_cnt_q        <= '0;
         lp_cnt_q        <= '0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_press_q    <= 1'b0;
         press_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         db_cnt_q        <= db_cnt_d;
         lp_cnt_q        <= lp_cnt_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_press_q    <= long_press_d;
         press_cnt_q     <= press_cnt_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      db_cnt_d        = '0;
      lp_cnt_d        = '0;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_press_d    = 1'b0;
      press_cnt_d     = press_cnt_q;

      // Any agreeing cycle leaves db_cnt_d at zero, so a bounce restarts the window.
      if (synced != state_q) begin
         if (db_cnt_q == DB_MAX) begin
            state_d = ~state_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end

      if ((state_q == RELEASED) && (state_d == PRESSED)) begin
         press_pulse_d = 1'b1;
         press_cnt_d   = press_cnt_q + COUNT_W'(1);
      end
      if ((state_q == PRESSED) && (state_d == RELEASED)) begin
         release_pulse_d = 1'b1;
      end

      // lp_cnt is 0 in the first PRESSED cycle and saturates at LP_MAX.
      if ((state_q == PRESSED) && (state_d == PRESSED)) begin
         if (lp_cnt_q != LP_MAX) begin
            lp_cnt_d = lp_cnt_q + LP_W'(1);
         end else begin
            lp_cnt_d = lp_cnt_q;
         end
      end
      if ((state_d == PRESSED) && (lp_cnt_d == LP_MAX) &&
          !((state_q == PRESSED) && (lp_cnt_q == LP_MAX))) begin
         long_press_d = 1'b1;
      end
   end

   assign pressed       = state_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_press    = long_press_q;
   assign press_count   = press_cnt_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DB_CNT=4, LP_CNT=20, active-low pin, 2-bit press count.
module tb_button_debounce;

   localparam int COUNT_W = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               btn;
   logic               pressed;
   logic               press_pulse;
   logic               release_pulse;
   logic               long_press;
   logic [COUNT_W-1:0] press_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       btn;
      logic       rst;
      logic [5:0] exp; // {pressed, press_pulse, release_pulse, long_press, press_count}
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   button_debounce #(
      .CLK_FREQ      (1000),
      .DEBOUNCE_MS   (4),
      .LONG_PRESS_MS (20),
      .ACTIVE_LOW    (1),
      .COUNT_W       (COUNT_W)
   ) dut (
      .CLK           (clk),
      .RESET         (rst),
      .BTN_IN        (btn),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .press_count   (press_count)
   );

   task automatic add(input logic b, input logic r, input logic p, input logic ppe,
                      input logic rpe, input logic lpe, input logic [1:0] c);
      vec_t v;
      v.btn = b;
      v.rst = r;
      v.exp = {p, ppe, rpe, lpe, c};
      vecs.push_back(v);
   endtask

   task automatic add_reset(input int n, input logic b);
      for (int k = 0; k < n; k++) add(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic add_idle(input int n, input logic b, input logic p, input logic [1:0] c);
      for (int k = 0; k < n; k++) add(b, 1'b0, p, 1'b0, 1'b0, 1'b0, c);
   endtask

   // New pin level: five cycles of unchanged output, then acceptance on the sixth.
   task automatic add_accept(input logic b, input logic pnew, input logic [1:0] cb, input logic [1:0] ca);
      for (int k = 0; k < 5; k++) add(b, 1'b0, !pnew, 1'b0, 1'b0, 1'b0, cb);
      add(b, 1'b0, pnew, pnew, !pnew, 1'b0, ca);
   endtask

   task automatic step_and_check_pulses();
      @(posedge clk);
      #1;
      checks++;
      if (press_pulse && release_pulse) begin
         errors++;
         $display("FAIL both_pulses: press_pulse=%b release_pulse=%b required not both 1", press_pulse, release_pulse);
      end
   endtask

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   initial begin
      logic [5:0] got;
      int         pp_seen;
      int         pp_at;
      int         lp_seen;

      btn = 1'b1;
      rst = 1'b1;

      add_reset(2, 1'b1);
      // Clean press, then long press held 40 cycles after acceptance.
      add_accept(1'b0, 1'b1, 2'd0, 2'd1);
      for (int k = 1; k <= 40; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (k == 19), 2'd1);
      add_accept(1'b1, 1'b0, 2'd1, 2'd1);
      add_idle(3, 1'b1, 1'b0, 2'd1);
      // Short press: no long_press.
      add_accept(1'b0, 1'b1, 2'd1, 2'd2);
      add_idle(10, 1'b0, 1'b1, 2'd2);
      add_accept(1'b1, 1'b0, 2'd2, 2'd2);
      add_idle(2, 1'b1, 1'b0, 2'd2);
      // Wrap: counts 1,2,3,0,1 from a fresh reset.
      add_reset(2, 1'b1);
      for (int n = 1; n <= 5; n++) begin
         logic [1:0] c;
         c = 2'(n);
         add_accept(1'b0, 1'b1, c - 2'd1, c);
         add_idle(2, 1'b0, 1'b1, c);
         add_accept(1'b1, 1'b0, c, c);
         add_idle(1, 1'b1, 1'b0, c);
      end
      // Reset two cycles into the debounce window with the button held.
      add_idle(4, 1'b0, 1'b0, 2'd1);
      add_reset(2, 1'b0);
      add_accept(1'b0, 1'b1, 2'd0, 2'd1);
      add_accept(1'b1, 1'b0, 2'd1, 2'd1);
      add_idle(2, 1'b1, 1'b0, 2'd1);

      foreach (vecs[i]) begin
         btn = vecs[i].btn;
         rst = vecs[i].rst;
         step_and_check_pulses();
         got = {pressed, press_pulse, release_pulse, long_press, press_count};
         checks++;
         if (got !== vecs[i].exp) begin
            errors++;
            $display("FAIL row%0d: got p/pp/rp/lp/cnt=%b required %b", i, got, vecs[i].exp);
         end
      end

      // Bounce: pin toggles every 2 cycles for 20 cycles, then holds pressed.
      pp_seen = 0;
      pp_at   = -1;
      lp_seen = 0;
      for (int i = 0; i < 40; i++) begin
         btn = (i < 20) ? logic'((i / 2) % 2) : 1'b0;
         rst = 1'b0;
         step_and_check_pulses();
         if (press_pulse) begin
            pp_seen++;
            if (pp_at < 0) pp_at = i;
         end
         if (long_press) lp_seen++;
      end
      check("bounce_pulse_count", pp_seen, 1);
      check("bounce_pulse_cycle", pp_at, 25);
      check("bounce_pressed", int'(pressed), 1);
      check("bounce_press_count", int'(press_count), 2);
      check("bounce_no_long_yet", lp_seen, 0);

      // Hold on to confirm exactly one long_press after the bounced press.
      lp_seen = 0;
      for (int i = 0; i < 30; i++) begin
         step_and_check_pulses();
         if (long_press) lp_seen++;
      end
      check("bounce_long_press_once", lp_seen, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
